// File: rtl/enc_pixel_writer.sv
// Plots the PmodEnc-selected colour at (x,y) into packed 8-bit pixel RAM via port B
// using read-modify-write, and provides a full pixel-area clear.
module enc_pixel_writer #(
    parameter logic [15:0] BASE_ADDR = 16'h1000,
    parameter int          WIDTH     = 160,
    parameter int          HEIGHT    = 120
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  x_pos,
    input  logic [7:0]  y_pos,
    input  logic [7:0]  color,
    input  logic        clear,
    input  logic [15:0] ram_rdata,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_RD   = 3'd2,
        S_MRG  = 3'd3,
        S_WR   = 3'd4,
        S_CLR  = 3'd5
    } state_t;

    localparam logic [8:0]  WIDTH_C  = 9'(WIDTH);
    localparam logic [8:0]  HEIGHT_C = 9'(HEIGHT);
    localparam logic [15:0] HALF_W   = 16'(WIDTH / 2);
    localparam logic [15:0] CLR_LAST = 16'((WIDTH * HEIGHT) / 2 - 1);

    state_t      state_q, state_d;
    logic        clr_pend_q, clr_pend_d;
    logic [7:0]  lx_q, lx_d, ly_q, ly_d, lc_q, lc_d;
    logic [15:0] addr_q, addr_d;
    logic        sel_hi_q, sel_hi_d;
    logic [15:0] merged_q, merged_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_wdata_q, ram_wdata_d;
    logic        ram_we_q, ram_we_d;
    logic        busy_q, busy_d;
    logic        chg_s;
    logic        in_range_s;

    // Even x lives in the high byte, odd x in the low byte.
    function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                               input logic [7:0]  px,
                                               input logic        hi);
        return hi ? {px, word[7:0]} : {word[15:8], px};
    endfunction

    assign chg_s      = ({x_pos, y_pos, color} != {lx_q, ly_q, lc_q});
    assign in_range_s = ({1'b0, x_pos} < WIDTH_C) && ({1'b0, y_pos} < HEIGHT_C);

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        clr_pend_d  = clr_pend_q | clear;
        lx_d        = lx_q;
        ly_d        = ly_q;
        lc_d        = lc_q;
        addr_d      = addr_q;
        sel_hi_d    = sel_hi_q;
        merged_d    = merged_q;
        cnt_d       = cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_pend_q) begin
                    // A pulse landing in this very cycle queues one more clear.
                    clr_pend_d = clear;
                    cnt_d      = 16'd0;
                    state_d    = S_CLR;
                end else if (chg_s) begin
                    lx_d    = x_pos;
                    ly_d    = y_pos;
                    lc_d    = color;
                    state_d = in_range_s ? S_CALC : S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                addr_d   = BASE_ADDR + 16'(ly_q) * HALF_W + {9'd0, lx_q[7:1]};
                sel_hi_d = ~lx_q[0];
                state_d  = S_RD;
            end
            S_RD: begin
                ram_addr_d = addr_q;
                state_d    = S_MRG;
            end
            S_MRG: begin
                merged_d = merge_byte(ram_rdata, lc_q, sel_hi_q);
                state_d  = S_WR;
            end
            S_WR: begin
                ram_addr_d  = addr_q;
                ram_wdata_d = merged_q;
                ram_we_d    = 1'b1;
                state_d     = S_IDLE;
            end
            S_CLR: begin
                ram_addr_d  = BASE_ADDR + cnt_q;
                ram_wdata_d = 16'h0000;
                ram_we_d    = 1'b1;
                if (cnt_q == CLR_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_CLR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            clr_pend_q  <= 1'b0;
            lx_q        <= 8'd0;
            ly_q        <= 8'd0;
            lc_q        <= 8'd0;
            addr_q      <= 16'd0;
            sel_hi_q    <= 1'b0;
            merged_q    <= 16'd0;
            cnt_q       <= 16'd0;
            ram_addr_q  <= 16'd0;
            ram_wdata_q <= 16'd0;
            ram_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_pend_q  <= clr_pend_d;
            lx_q        <= lx_d;
            ly_q        <= ly_d;
            lc_q        <= lc_d;
            addr_q      <= addr_d;
            sel_hi_q    <= sel_hi_d;
            merged_q    <= merged_d;
            cnt_q       <= cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            busy_q      <= busy_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign busy      = busy_q;

endmodule
